// File: rtl/dft_seq_pkg.sv
// Shared encodings for the DUT/DFT sequencing controller: opcodes, FSM states,
// error codes and the status word layout.
package dft_seq_pkg;

  localparam logic [31:0] OP_NONE  = 32'd0;
  localparam logic [31:0] OP_INPUT = 32'd1;
  localparam logic [31:0] OP_RUN   = 32'd2;
  localparam logic [31:0] OP_ENDR  = 32'd3;
  localparam logic [31:0] OP_TEST  = 32'd4;
  localparam logic [31:0] OP_NEXT  = 32'd5;
  localparam logic [31:0] OP_ENDT  = 32'd6;
  localparam logic [31:0] OP_ABORT = 32'd7;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_IN_FLAT   = 4'd1;
  localparam logic [3:0] ST_IN_DUT    = 4'd2;
  localparam logic [3:0] ST_IN_RDY    = 4'd3;
  localparam logic [3:0] ST_OUT_WAIT  = 4'd4;
  localparam logic [3:0] ST_OUT_VAL   = 4'd5;
  localparam logic [3:0] ST_OUT_PACK  = 4'd6;
  localparam logic [3:0] ST_SCAN_PREP = 4'd7;
  localparam logic [3:0] ST_SCAN      = 4'd8;
  localparam logic [3:0] ST_SCAN_RD   = 4'd9;
  localparam logic [3:0] ST_TICK      = 4'd10;
  localparam logic [3:0] ST_ERR       = 4'd11;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_WDOG = 2'd1;
  localparam logic [1:0] ERR_MASK = 2'd2;

  // Field order fixes the status bit positions, LSB last.
  typedef struct packed {
    logic [2:0]  rsvd;        // [31:29]
    logic [15:0] snap_cnt;    // [28:13]
    logic        ovf;         // [12]
    logic [1:0]  err;         // [11:10]
    logic        all_commit;  // [9]
    logic        all_ack;     // [8]
    logic        commit_ack;  // [7]
    logic        op_commit;   // [6]
    logic        op_ack;      // [5]
    logic        val_op;      // [4]
    logic [3:0]  state;       // [3:0]
  } status_t;

endpackage

// File: rtl/dft_seq_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);
  assign at_max = (value == MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) value <= '0;
    else if (en && !at_max) value <= value + 1'b1;
  end
endmodule

// File: rtl/dft_seq_ctrl.sv
// Sequences the DUT through input flattening / run / output packing, and the
// masked scan chains through capture / scan / readout, with watchdog and abort.
module dft_seq_ctrl
  import dft_seq_pkg::*;
#(
  parameter int P_CHAINS    = 16,
  parameter int P_IN_WIDTH  = 256,
  parameter int P_OUT_WIDTH = 256,
  parameter int P_AW        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              opcode,
  input  logic [P_CHAINS-1:0]      cfg_chain_mask,
  input  logic [15:0]              cfg_ticks,
  input  logic [15:0]              cfg_timeout,
  output logic                     dut_val_op,
  input  logic                     dut_op_ack,
  input  logic                     dut_op_commit,
  output logic                     dut_commit_ack,
  output logic                     dut_sen,
  output logic                     dut_rst,
  output logic [P_CHAINS-1:0]      dft_val_op,
  input  logic [P_CHAINS-1:0]      dft_op_ack,
  input  logic [P_CHAINS-1:0]      dft_op_commit,
  input  logic [P_CHAINS-1:0]      dft_strobe,
  output logic [P_CHAINS-1:0]      dft_commit_ack,
  output logic [31:0]              in_rdaddr,
  output logic [31:0]              out_wraddr,
  output logic                     in_vec_en,
  output logic                     in_vec_mode,
  output logic                     out_vec_en,
  output logic                     out_vec_mode,
  output logic                     dut_in_ren,
  output logic                     dut_out_wen,
  output logic [P_CHAINS-1:0]      chain_wen,
  output logic [P_CHAINS*P_AW-1:0] chain_wraddr,
  output logic [31:0]              status
);
  localparam int IN_WORDS  = (P_IN_WIDTH + 31) / 32;
  localparam int OUT_WORDS = (P_OUT_WIDTH + 31) / 32;

  logic [3:0]                     state, nxt;
  logic [1:0]                     err, err_nxt;
  logic [P_CHAINS-1:0]            mask_q;
  logic [15:0]                    snap_cnt, wd_cnt;
  logic                           ovf, flat_last, pack_last, wd_max;
  logic                           all_ack, all_commit, auto_mode, scan_end, wd_wait, wd_exp;
  logic [P_CHAINS-1:0][P_AW-1:0]  chain_addr;
  logic [P_CHAINS-1:0]            chain_max;
  status_t                        st;

  assign all_ack    = &(dft_op_ack | ~mask_q);
  assign all_commit = &(dft_op_commit | ~mask_q);
  assign auto_mode  = (cfg_ticks != 16'd0);
  assign scan_end   = auto_mode ? (snap_cnt >= cfg_ticks) : (opcode == OP_ENDT);
  assign wd_wait    = state inside {ST_IN_DUT, ST_OUT_WAIT, ST_SCAN_PREP, ST_SCAN};
  assign wd_exp     = wd_wait && (cfg_timeout != 16'd0) && (wd_cnt == cfg_timeout - 16'd1);

  always_comb begin
    nxt     = state;
    err_nxt = err;
    if (opcode == OP_ABORT && state != ST_IDLE) nxt = ST_IDLE;
    else if (wd_exp) begin
      nxt     = ST_ERR;
      err_nxt = ERR_WDOG;
    end else begin
      case (state)
        ST_IDLE:      if (opcode == OP_INPUT) nxt = ST_IN_FLAT;
        ST_IN_FLAT:   if (flat_last) nxt = ST_IN_DUT;
        ST_IN_DUT:    if (dut_op_ack) nxt = ST_IN_RDY;
        ST_IN_RDY: begin
          if (opcode == OP_RUN) nxt = ST_OUT_WAIT;
          else if (opcode == OP_TEST) begin
            if (|cfg_chain_mask) nxt = ST_SCAN_PREP;
            else begin
              nxt     = ST_ERR;
              err_nxt = ERR_MASK;
            end
          end
        end
        ST_OUT_WAIT:  if (dut_op_commit) nxt = ST_OUT_VAL;
        ST_OUT_VAL:   if (opcode == OP_ENDR) nxt = ST_OUT_PACK;
        ST_OUT_PACK:  if (pack_last) nxt = ST_IDLE;
        ST_SCAN_PREP: if (all_ack) nxt = ST_SCAN;
        ST_SCAN:      if (all_commit) nxt = ST_SCAN_RD;
        ST_SCAN_RD: begin
          if (scan_end) nxt = ST_IDLE;
          else if (auto_mode || opcode == OP_NEXT) nxt = ST_TICK;
        end
        ST_TICK:      nxt = ST_SCAN_PREP;
        ST_ERR:       nxt = ST_ERR;
        default:      nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      err      <= ERR_NONE;
      mask_q   <= '0;
      snap_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= nxt;
      err   <= err_nxt;
      if (state == ST_IN_RDY && nxt == ST_SCAN_PREP) mask_q <= cfg_chain_mask;
      // Sticky results survive the return to IDLE so software can read them.
      if (state == ST_IDLE && nxt == ST_IN_FLAT) begin
        err      <= ERR_NONE;
        ovf      <= 1'b0;
        snap_cnt <= '0;
      end else begin
        if (state == ST_SCAN && nxt == ST_SCAN_RD) snap_cnt <= snap_cnt + 16'd1;
        if (|(chain_wen & chain_max)) ovf <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(32), .MAX(32'(IN_WORDS - 1))) u_flat (
    .clk(clk), .reset(reset), .clr(state != ST_IN_FLAT), .en(1'b1),
    .value(in_rdaddr), .at_max(flat_last));

  sat_counter #(.WIDTH(32), .MAX(32'(OUT_WORDS - 1))) u_pack (
    .clk(clk), .reset(reset), .clr(state != ST_OUT_PACK), .en(1'b1),
    .value(out_wraddr), .at_max(pack_last));

  sat_counter #(.WIDTH(16)) u_wdog (
    .clk(clk), .reset(reset), .clr(!wd_wait || nxt != state), .en(1'b1),
    .value(wd_cnt), .at_max(wd_max));

  for (genvar g = 0; g < P_CHAINS; g++) begin : g_chain
    sat_counter #(.WIDTH(P_AW)) u_addr (
      .clk(clk), .reset(reset), .clr(state == ST_IDLE || state == ST_TICK),
      .en(chain_wen[g]), .value(chain_addr[g]), .at_max(chain_max[g]));
  end

  assign chain_wraddr = chain_addr;

  always_comb begin
    dut_val_op     = 1'b0;
    dut_commit_ack = 1'b0;
    dut_sen        = 1'b0;
    dut_rst        = 1'b0;
    dft_val_op     = '0;
    dft_commit_ack = '0;
    in_vec_en      = 1'b0;
    in_vec_mode    = 1'b1;
    out_vec_en     = 1'b0;
    out_vec_mode   = 1'b1;
    dut_in_ren     = 1'b0;
    dut_out_wen    = 1'b0;
    chain_wen      = '0;
    case (state)
      ST_IDLE, ST_ERR: dut_rst = 1'b1;
      ST_IN_FLAT: begin in_vec_en = 1'b1; dut_in_ren = 1'b1; end
      ST_IN_DUT:  begin dut_val_op = 1'b1; in_vec_en = 1'b1; in_vec_mode = 1'b0; end
      ST_IN_RDY:  begin dut_sen = 1'b1; in_vec_en = 1'b1; in_vec_mode = 1'b0; end
      ST_OUT_VAL: out_vec_en = 1'b1;
      ST_OUT_PACK: begin
        dut_commit_ack = 1'b1;
        dut_out_wen    = 1'b1;
        out_vec_en     = 1'b1;
        out_vec_mode   = 1'b0;
      end
      ST_SCAN_PREP: begin dut_sen = 1'b1; dft_val_op = mask_q; end
      ST_SCAN:      chain_wen = dft_strobe & mask_q;
      ST_SCAN_RD: begin
        dft_commit_ack = mask_q;
        // The final readout cycle releases the DUT result instead of holding scan.
        if (scan_end && opcode != OP_ABORT) dut_commit_ack = 1'b1;
        else dut_sen = 1'b1;
      end
      default: ;
    endcase
  end

  // An empty mask never reports as handshake-complete.
  assign st.rsvd       = 3'd0;
  assign st.snap_cnt   = snap_cnt;
  assign st.ovf        = ovf;
  assign st.err        = err;
  assign st.all_commit = all_commit & (|mask_q);
  assign st.all_ack    = all_ack & (|mask_q);
  assign st.commit_ack = dut_commit_ack;
  assign st.op_commit  = dut_op_commit;
  assign st.op_ack     = dut_op_ack;
  assign st.val_op     = dut_val_op;
  assign st.state      = state;
  assign status        = st;
endmodule

// File: tb/tb_dft_seq_ctrl.sv
// Directed bench for dft_seq_ctrl: run flow, masked/auto scan, watchdog,
// address saturation and error/reset corners, with an address scoreboard.
module tb_dft_seq_ctrl;
  import dft_seq_pkg::*;

  localparam int CH = 16;
  localparam int AW = 4;
  localparam int IN_WORDS = 8;
  localparam int OUT_WORDS = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [31:0]         opcode = '0;
  logic [CH-1:0]       cfg_chain_mask = '0;
  logic [15:0]         cfg_ticks = '0, cfg_timeout = '0;
  logic                dut_val_op, dut_op_ack = 1'b0, dut_op_commit = 1'b0, dut_commit_ack;
  logic                dut_sen, dut_rst;
  logic [CH-1:0]       dft_val_op, dft_op_ack = '0, dft_op_commit = '0, dft_strobe = '0;
  logic [CH-1:0]       dft_commit_ack, chain_wen;
  logic [31:0]         in_rdaddr, out_wraddr, status;
  logic                in_vec_en, in_vec_mode, out_vec_en, out_vec_mode, dut_in_ren, dut_out_wen;
  logic [CH*AW-1:0]    chain_wraddr;

  int total = 0, bad = 0;
  int n_in = 0, n_out = 0;
  logic [31:0] in_q[$], out_q[$];

  dft_seq_ctrl #(.P_CHAINS(CH), .P_IN_WIDTH(256), .P_OUT_WIDTH(256), .P_AW(AW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cfg_chain_mask(cfg_chain_mask),
    .cfg_ticks(cfg_ticks), .cfg_timeout(cfg_timeout), .dut_val_op(dut_val_op),
    .dut_op_ack(dut_op_ack), .dut_op_commit(dut_op_commit), .dut_commit_ack(dut_commit_ack),
    .dut_sen(dut_sen), .dut_rst(dut_rst), .dft_val_op(dft_val_op), .dft_op_ack(dft_op_ack),
    .dft_op_commit(dft_op_commit), .dft_strobe(dft_strobe), .dft_commit_ack(dft_commit_ack),
    .in_rdaddr(in_rdaddr), .out_wraddr(out_wraddr), .in_vec_en(in_vec_en),
    .in_vec_mode(in_vec_mode), .out_vec_en(out_vec_en), .out_vec_mode(out_vec_mode),
    .dut_in_ren(dut_in_ren), .dut_out_wen(dut_out_wen), .chain_wen(chain_wen),
    .chain_wraddr(chain_wraddr), .status(status));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: addresses expected per serial-in / pack cycle.
  always @(negedge clk) begin
    if (!reset && in_vec_en && in_vec_mode) begin
      n_in++;
      chk("in_q_nonempty", in_q.size() != 0, 1);
      if (in_q.size() != 0) chk("in_rdaddr", in_rdaddr, in_q.pop_front());
    end
    if (!reset && dut_out_wen) begin
      n_out++;
      chk("out_q_nonempty", out_q.size() != 0, 1);
      if (out_q.size() != 0) chk("out_wraddr", out_wraddr, out_q.pop_front());
    end
  end

  task automatic op(logic [31:0] c);
    opcode = c;
    @(negedge clk);
    opcode = OP_NONE;
  endtask

  task automatic wait_state(logic [3:0] s, int budget, string tag);
    int n = 0;
    while (status[3:0] !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, status[3:0], s);
  endtask

  task automatic to_rdy();
    for (int i = 0; i < IN_WORDS; i++) in_q.push_back(i);
    op(OP_INPUT);
    wait_state(ST_IN_DUT, 20, "reach_in_dut");
    dut_op_ack = 1'b1;
    @(negedge clk);
    dut_op_ack = 1'b0;
    chk("reach_in_rdy", status[3:0], ST_IN_RDY);
  endtask

  task automatic scan_pass(logic [CH-1:0] m);
    wait_state(ST_SCAN_PREP, 10, "reach_prep");
    chk("dft_val_op", dft_val_op, m);
    dft_op_ack = m;
    @(negedge clk);
    dft_op_ack = '0;
    chk("reach_scan", status[3:0], ST_SCAN);
    dft_strobe = '1;
    #1 chk("chain_wen_masked", chain_wen, m);
    @(negedge clk);
    dft_strobe = '0;
    dft_op_commit = m;
    @(negedge clk);
    dft_op_commit = '0;
    chk("reach_scan_rd", status[3:0], ST_SCAN_RD);
    chk("dft_commit_ack", dft_commit_ack, m);
    chk("scan_rd_sen", dut_sen, 1);
  endtask

  initial begin
    int n, rd, cack, wen;
    repeat (3) @(negedge clk);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_status", status, 0);
    chk("rst_modes", {in_vec_mode, out_vec_mode}, 2'b11);
    chk("rst_valids", {dut_val_op, dft_val_op, dut_sen, in_vec_en, out_vec_en}, 0);
    chk("rst_addrs", {in_rdaddr, out_wraddr}, 0);
    chk("rst_chain_addr", chain_wraddr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Run flow: ack 3 cycles late, commit 5 cycles late.
    for (int i = 0; i < IN_WORDS; i++) in_q.push_back(i);
    for (int i = 0; i < OUT_WORDS; i++) out_q.push_back(i);
    op(OP_INPUT);
    wait_state(ST_IN_DUT, 20, "run_in_dut");
    chk("run_val_op", dut_val_op, 1);
    repeat (3) @(negedge clk);
    dut_op_ack = 1'b1;
    @(negedge clk);
    dut_op_ack = 1'b0;
    chk("run_in_rdy_sen", {status[3:0], dut_sen}, {ST_IN_RDY, 1'b1});
    op(OP_RUN);
    chk("run_out_wait", status[3:0], ST_OUT_WAIT);
    repeat (5) @(negedge clk);
    dut_op_commit = 1'b1;
    @(negedge clk);
    dut_op_commit = 1'b0;
    chk("run_out_val", {status[3:0], out_vec_en, out_vec_mode}, {ST_OUT_VAL, 2'b11});
    op(OP_ENDR);
    wait_state(ST_IDLE, 20, "run_idle");
    chk("run_in_cycles", n_in, IN_WORDS);
    chk("run_out_cycles", n_out, OUT_WORDS);
    chk("run_queues_drained", in_q.size() + out_q.size(), 0);

    // Masked manual test: chains 8-15 never ack.
    cfg_chain_mask = 16'h00FF;
    to_rdy();
    op(OP_TEST);
    scan_pass(16'h00FF);
    op(OP_NEXT);
    scan_pass(16'h00FF);
    op(OP_NEXT);
    scan_pass(16'h00FF);
    opcode = OP_ENDT;
    #1 chk("endt_commit_ack", {dut_commit_ack, dut_sen}, 2'b10);
    @(negedge clk);
    opcode = OP_NONE;
    chk("masked_idle", status[3:0], ST_IDLE);
    chk("masked_snap", status[28:13], 3);

    // Autonomous mode, 4 snapshots, no NEXT.
    cfg_chain_mask = 16'hFFFF;
    cfg_ticks = 16'd4;
    to_rdy();
    op(OP_TEST);
    rd = 0; cack = 0; n = 0;
    while (status[3:0] !== ST_IDLE && n < 200) begin
      if (status[3:0] == ST_SCAN_RD) rd++;
      if (dut_commit_ack) cack++;
      dft_op_ack = dft_val_op;
      dft_op_commit = (status[3:0] == ST_SCAN) ? '1 : '0;
      @(negedge clk);
      n++;
    end
    dft_op_ack = '0;
    dft_op_commit = '0;
    chk("auto_idle", status[3:0], ST_IDLE);
    chk("auto_rd_visits", rd, 4);
    chk("auto_commit_pulses", cack, 1);
    chk("auto_snap", status[28:13], 4);
    cfg_ticks = 16'd0;

    // Watchdog: ack never arrives.
    cfg_timeout = 16'd10;
    for (int i = 0; i < IN_WORDS; i++) in_q.push_back(i);
    op(OP_INPUT);
    wait_state(ST_IN_DUT, 20, "wd_in_dut");
    n = 0;
    while (status[3:0] === ST_IN_DUT && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("wd_cycles", n, 10);
    chk("wd_err_state", status[3:0], ST_ERR);
    chk("wd_err_code", status[11:10], ERR_WDOG);
    chk("wd_rst", {dut_rst, dut_val_op}, 2'b10);
    op(OP_ABORT);
    chk("wd_abort_idle", status[3:0], ST_IDLE);
    cfg_timeout = 16'd0;

    // Saturation on chain 0.
    cfg_chain_mask = 16'h0001;
    to_rdy();
    op(OP_TEST);
    dft_op_ack = 16'h0001;
    @(negedge clk);
    dft_op_ack = '0;
    chk("sat_scan", status[3:0], ST_SCAN);
    wen = 0;
    dft_strobe = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      #1 if (chain_wen[0]) wen++;
      @(negedge clk);
    end
    dft_strobe = '0;
    chk("sat_addr", chain_wraddr[AW-1:0], 15);
    chk("sat_others", chain_wraddr[CH*AW-1:AW], 0);
    chk("sat_wen_pulses", wen, 20);
    chk("sat_ovf", status[12], 1);
    op(OP_ABORT);
    chk("sat_abort_idle", status[3:0], ST_IDLE);

    // Empty mask on TEST.
    cfg_chain_mask = '0;
    to_rdy();
    op(OP_TEST);
    chk("mask0_err", {status[3:0], status[11:10]}, {ST_ERR, ERR_MASK});
    op(OP_ABORT);

    // Reset while scanning.
    cfg_chain_mask = 16'hFFFF;
    to_rdy();
    op(OP_TEST);
    dft_op_ack = '1;
    @(negedge clk);
    dft_op_ack = '0;
    chk("rstscan_scan", status[3:0], ST_SCAN);
    reset = 1'b1;
    @(negedge clk);
    chk("rstscan_status", status, 0);
    chk("rstscan_outs", {dut_rst, dut_sen, dut_commit_ack, dft_val_op, dft_commit_ack, chain_wen},
        {1'b1, 2'b00, 48'h0});
    chk("rstscan_modes", {in_vec_mode, out_vec_mode}, 2'b11);
    reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1, "timeout");
  end
endmodule
